// File: rtl/cgra_inst_sequencer.sv
// CGRA instruction sequencer: walks the instruction ROM address range
// [0, Inst_Last_Addr] for a latched number of passes, holds PE_Array_Busy
// through a drain tail that covers ROM latency and PE writeback, then
// raises a sticky Computation_Done until the next accepted Start.
// Optional feature macro: CGRA_CYCLE_CNT_EN adds the 32-bit saturating
// Cycle_Cnt output counting every RUN/DRAIN cycle of the latest run.
module cgra_inst_sequencer #(
  parameter int unsigned INST_AWIDTH  = 10,
  parameter int unsigned ITER_WIDTH   = 16,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Resetn,
  input  logic                   Start,
  input  logic [INST_AWIDTH-1:0] Inst_Last_Addr,
  input  logic [ITER_WIDTH-1:0]  Iter_Num,
  input  logic                   Stall,
  output logic [INST_AWIDTH-1:0] Inst_Mem_Addr,
  output logic                   PE_Array_Busy,
  output logic                   Computation_Done,
  output logic [ITER_WIDTH-1:0]  Iter_Cnt
`ifdef CGRA_CYCLE_CNT_EN
  ,
  output logic [31:0]            Cycle_Cnt
`endif
);

  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [INST_AWIDTH-1:0] addr_q;
  logic [INST_AWIDTH-1:0] last_q;
  logic [ITER_WIDTH-1:0]  iter_q;
  logic [ITER_WIDTH-1:0]  iters_q;
  logic [ITER_WIDTH-1:0]  iters_d;
  logic [DCW-1:0]         drain_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   accept;
  logic                   addr_at_last;
  logic                   last_pass;
  logic                   drain_end;

  // A pass count of zero runs the program once.
  assign iters_d      = (Iter_Num == '0) ? ITER_WIDTH'(1) : Iter_Num;
  assign accept       = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Compare before incrementing so Last at the top of the address space never wraps.
  assign addr_at_last = (addr_q == last_q);
  assign last_pass    = (iter_q == (iters_q - ITER_WIDTH'(1)));
  assign drain_end    = (drain_q == DCW'(DRAIN_CYCLES - 1));

  // Sequencer FSM; every output is driven straight from a register.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      iter_q  <= '0;
      iters_q <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            last_q  <= Inst_Last_Addr;
            iters_q <= iters_d;
            addr_q  <= '0;
            iter_q  <= '0;
            drain_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!Stall) begin
            if (!addr_at_last) begin
              addr_q <= addr_q + INST_AWIDTH'(1);
            end else if (!last_pass) begin
              addr_q <= '0;
              iter_q <= iter_q + ITER_WIDTH'(1);
            end else begin
              drain_q <= '0;
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!Stall) begin
            if (drain_end) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              addr_q  <= '0;
              state_q <= S_DONE;
            end else begin
              drain_q <= drain_q + DCW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Inst_Mem_Addr    = addr_q;
  assign PE_Array_Busy    = busy_q;
  assign Computation_Done = done_q;
  assign Iter_Cnt         = iter_q;

`ifdef CGRA_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  // Run-length counter: cleared on accept, counts stalled cycles too, saturates.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      cyc_q <= '0;
    end else if (accept) begin
      cyc_q <= '0;
    end else if (((state_q == S_RUN) || (state_q == S_DRAIN)) && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign Cycle_Cnt = cyc_q;
`endif

endmodule

// File: tb/tb_cgra_inst_sequencer.sv
// Directed self-checking bench for cgra_inst_sequencer (default parameters,
// DRAIN_CYCLES = 2). Inputs change and outputs are sampled on the falling edge.
module tb_cgra_inst_sequencer;

  logic        Clk;
  logic        Resetn;
  logic        Start;
  logic [9:0]  Inst_Last_Addr;
  logic [15:0] Iter_Num;
  logic        Stall;
  logic [9:0]  Inst_Mem_Addr;
  logic        PE_Array_Busy;
  logic        Computation_Done;
  logic [15:0] Iter_Cnt;
`ifdef CGRA_CYCLE_CNT_EN
  logic [31:0] Cycle_Cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int nb;

  logic [9:0]  cap_addr [0:2047];
  logic [15:0] cap_iter [0:2047];

  cgra_inst_sequencer #(
    .INST_AWIDTH  (10),
    .ITER_WIDTH   (16),
    .DRAIN_CYCLES (2)
  ) dut (
    .Clk              (Clk),
    .Resetn           (Resetn),
    .Start            (Start),
    .Inst_Last_Addr   (Inst_Last_Addr),
    .Iter_Num         (Iter_Num),
    .Stall            (Stall),
    .Inst_Mem_Addr    (Inst_Mem_Addr),
    .PE_Array_Busy    (PE_Array_Busy),
    .Computation_Done (Computation_Done),
    .Iter_Cnt         (Iter_Cnt)
`ifdef CGRA_CYCLE_CNT_EN
    ,
    .Cycle_Cnt        (Cycle_Cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Launch a run and capture one sample per busy cycle. smask bit i drives
  // Stall for the edge ending busy cycle i; spulse re-pulses Start mid-run.
  task automatic run(input logic [9:0] last, input logic [15:0] iters,
                     input logic [63:0] smask, input int spulse, output int n);
    Inst_Last_Addr = last;
    Iter_Num       = iters;
    Stall          = 1'b0;
    Start          = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    expect_eq("start_busy", PE_Array_Busy, 1);
    expect_eq("start_done", Computation_Done, 0);
    expect_eq("start_addr", Inst_Mem_Addr, 0);
`ifdef CGRA_CYCLE_CNT_EN
    expect_eq("start_cyc", Cycle_Cnt, 0);
`endif
    n = 0;
    while (PE_Array_Busy && n < 2000) begin
      cap_addr[n] = Inst_Mem_Addr;
      cap_iter[n] = Iter_Cnt;
      Stall = (n < 64) ? smask[n] : 1'b0;
      if (n == spulse) begin
        Start          = 1'b1;
        Inst_Last_Addr = 10'd0;
        Iter_Num       = 16'd5;
      end else begin
        Start = 1'b0;
      end
      n++;
      @(negedge Clk);
    end
    Start = 1'b0;
    Stall = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    Resetn         = 1'b0;
    Start          = 1'b0;
    Stall          = 1'b0;
    Inst_Last_Addr = '0;
    Iter_Num       = '0;
    @(negedge Clk);
    @(negedge Clk);
    expect_eq("rst_addr", Inst_Mem_Addr, 0);
    expect_eq("rst_busy", PE_Array_Busy, 0);
    expect_eq("rst_done", Computation_Done, 0);
    expect_eq("rst_iter", Iter_Cnt, 0);
    Resetn = 1'b1;

    // Stall in IDLE does nothing
    Stall = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Stall = 1'b0;
    expect_eq("idle_stall_busy", PE_Array_Busy, 0);
    expect_eq("idle_stall_addr", Inst_Mem_Addr, 0);

    begin : t_basic
      int ea [6] = '{0, 1, 2, 3, 3, 3};
      run(10'd3, 16'd1, 64'h0, -1, nb);
      expect_eq("basic_len", nb, 6);
      for (int i = 0; i < 6; i++) expect_eq($sformatf("basic_addr%0d", i), cap_addr[i], ea[i]);
      expect_eq("basic_done", Computation_Done, 1);
      expect_eq("basic_addr_end", Inst_Mem_Addr, 0);
`ifdef CGRA_CYCLE_CNT_EN
      expect_eq("basic_cyc", Cycle_Cnt, 6);
`endif
    end

    // Stall in DONE: outputs hold
    Stall = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Stall = 1'b0;
    expect_eq("done_stall_done", Computation_Done, 1);
    expect_eq("done_stall_busy", PE_Array_Busy, 0);
    expect_eq("done_stall_addr", Inst_Mem_Addr, 0);

    begin : t_multi
      int ea [11] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 2, 2};
      int ei [11] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2};
      run(10'd2, 16'd3, 64'h0, -1, nb);
      expect_eq("multi_len", nb, 11);
      for (int i = 0; i < 11; i++) begin
        expect_eq($sformatf("multi_addr%0d", i), cap_addr[i], ea[i]);
        expect_eq($sformatf("multi_iter%0d", i), cap_iter[i], ei[i]);
      end
      expect_eq("multi_done", Computation_Done, 1);
      expect_eq("multi_iter_end", Iter_Cnt, 2);
    end

    begin : t_stall
      int ea [9] = '{0, 1, 1, 1, 2, 3, 3, 3, 3};
      run(10'd3, 16'd1, 64'h46, -1, nb);
      expect_eq("stall_len", nb, 9);
      for (int i = 0; i < 9; i++) expect_eq($sformatf("stall_addr%0d", i), cap_addr[i], ea[i]);
      expect_eq("stall_done", Computation_Done, 1);
`ifdef CGRA_CYCLE_CNT_EN
      expect_eq("stall_cyc", Cycle_Cnt, 9);
`endif
    end

    begin : t_last0
      run(10'd0, 16'd0, 64'h0, -1, nb);
      expect_eq("last0_len", nb, 3);
      for (int i = 0; i < 3; i++) expect_eq($sformatf("last0_addr%0d", i), cap_addr[i], 0);
      expect_eq("last0_done", Computation_Done, 1);
    end

    begin : t_restart_ignored
      int ea [6] = '{0, 1, 2, 3, 3, 3};
      run(10'd3, 16'd1, 64'h0, 2, nb);
      expect_eq("ign_len", nb, 6);
      for (int i = 0; i < 6; i++) expect_eq($sformatf("ign_addr%0d", i), cap_addr[i], ea[i]);
      expect_eq("ign_done", Computation_Done, 1);
    end

    begin : t_lastmax
      run(10'd1023, 16'd1, 64'h0, -1, nb);
      expect_eq("max_len", nb, 1026);
      expect_eq("max_addr1022", cap_addr[1022], 1022);
      expect_eq("max_addr1023", cap_addr[1023], 1023);
      expect_eq("max_addr1025", cap_addr[1025], 1023);
      expect_eq("max_done", Computation_Done, 1);
    end

    begin : t_reset_mid
      int n;
      Inst_Last_Addr = 10'd5;
      Iter_Num       = 16'd1;
      Start          = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      n = 0;
      while (Inst_Mem_Addr != 10'd3 && n < 20) begin
        @(negedge Clk);
        n++;
      end
      expect_eq("rmid_reach3", Inst_Mem_Addr, 3);
      Resetn = 1'b0;
      @(negedge Clk);
      Resetn = 1'b1;
      expect_eq("rmid_addr", Inst_Mem_Addr, 0);
      expect_eq("rmid_busy", PE_Array_Busy, 0);
      expect_eq("rmid_done", Computation_Done, 0);
      expect_eq("rmid_iter", Iter_Cnt, 0);
      @(negedge Clk);
      expect_eq("rmid_idle_busy", PE_Array_Busy, 0);
      run(10'd1, 16'd2, 64'h0, -1, nb);
      expect_eq("rmid_rerun_len", nb, 6);
      expect_eq("rmid_rerun_done", Computation_Done, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cgra_inst_sequencer.md
Name: cgra_inst_sequencer

Overview:
- Controls the CGRA instruction memory and the PE array run phase.
- Accepts a start pulse and generates the instruction ROM address stream over a programmable number of passes.
- Asserts PE_Array_Busy for the whole run, including a pipeline drain tail, then raises a sticky Computation_Done.
- Sits between the host/DMA control logic and the instruction ROM (1-cycle read latency) feeding the PE array.

Parameters:
- INST_AWIDTH, 10: instruction memory address width.
- ITER_WIDTH, 16: width of the pass-count input and counter.
- DRAIN_CYCLES, 2: cycles Busy stays high after the final address is issued (ROM latency plus PE writeback). Must be >= 1.

Ports:
- Clk  input  1  system clock.
- Resetn  input  1  reset. Synchronous, active-low.
- Start  input  1  single-cycle run request. Sampled only in IDLE or DONE.
- Inst_Last_Addr  input  INST_AWIDTH  address of the final instruction, inclusive. Latched on accepted Start.
- Iter_Num  input  ITER_WIDTH  number of passes over the program. 0 is treated as 1. Latched on accepted Start.
- Stall  input  1  freezes sequencing while high.
- Inst_Mem_Addr  output  INST_AWIDTH  ROM read address.
- PE_Array_Busy  output  1  run in progress.
- Computation_Done  output  1  level signal, high from run completion until the next accepted Start.
- Iter_Cnt  output  ITER_WIDTH  index of the current pass, 0-based.
- Cycle_Cnt  output  32  run cycle count. Present only with CGRA_CYCLE_CNT_EN.

Behaviour:
- Reset:
  - Resetn low at a rising edge applies reset at that edge, in any state, including mid-run.
  - After reset: state IDLE, Inst_Mem_Addr=0, PE_Array_Busy=0, Computation_Done=0, Iter_Cnt=0, internal latches=0.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered.
- IDLE:
  - Addr=0, Busy=0.
  - Start=1 → latch Inst_Last_Addr and max(Iter_Num,1). Next state RUN with Busy=1, Addr=0, Iter_Cnt=0.
- RUN, Stall=0:
  - Addr != Last → Addr+1.
  - Addr == Last and Iter_Cnt < Iters-1 → Addr=0, Iter_Cnt+1.
  - Addr == Last and Iter_Cnt == Iters-1 → DRAIN. Addr holds, drain counter=0.
- RUN, Stall=1: Addr, Iter_Cnt and state hold.
- DRAIN:
  - Busy=1.
  - Drain counter increments when Stall=0 and holds when Stall=1.
  - After DRAIN_CYCLES non-stalled cycles → DONE with Busy=0, Done=1, Addr=0.
- DONE:
  - Outputs hold.
  - Start=1 → behaves as the IDLE acceptance and clears Done on the same edge.
- Start in RUN or DRAIN is ignored. Latched values cannot change mid-run.
- Timing with no stalls, Start accepted at edge k:
  - Busy rises after edge k.
  - Busy stays high exactly (Last+1)*Iters + DRAIN_CYCLES cycles.
  - Done rises on the edge on which Busy falls.
- Last=0: a single-instruction program, with one RUN cycle per pass.
- Last=2^INST_AWIDTH-1: Addr never increments past Last, so no overflow or wrap occurs before the compare.
- Iter_Num=0: identical to Iter_Num=1.
- Stall asserted in IDLE or DONE has no effect.

Optional Feature:
- Macro: CGRA_CYCLE_CNT_EN.
- Defined:
  - Cycle_Cnt port exists.
  - Cleared to 0 on accepted Start.
  - Increments every cycle in RUN and DRAIN, stalled cycles included.
  - Holds in DONE.
  - Reset value 0.
  - Saturates at 0xFFFFFFFF.
- Undefined: Cycle_Cnt port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset mid-run: Last=5, Iters=1, Resetn low during RUN at Addr=3 → next cycle Addr=0, Busy=0, Done=0, state IDLE. A later Start runs normally.
- Basic run: Last=3, Iters=1, DRAIN_CYCLES=2 → Addr sequence 0,1,2,3,3,3. Busy high exactly 6 cycles. Then Done=1, Addr=0.
- Multi-pass: Last=2, Iters=3 → Addr 0,1,2 repeated three times. Iter_Cnt steps 0→1→2. Busy high 11 cycles.
- Stall: Last=3, Iters=1, Stall high for 2 cycles at Addr=1 and 1 cycle in DRAIN → Addr holds at 1 for those cycles. Busy high 9 cycles. Cycle_Cnt=9 when enabled.
- Corners:
  - Last=0, Iters=0 → Busy high 3 cycles, Done=1.
  - Start pulsed again during RUN → ignored, run length unchanged.
- Restart from DONE: Start with Done=1 → Done=0 and Busy=1 on the same edge, Addr=0. Cycle_Cnt cleared to 0.
